// File: rtl/sixteen_bit_adder_pkg.sv
// Shared constants for the sixteen_bit_adder datapath.
// DATA_W     : full operand / sum width
// SLICE_W    : width of one ripple slice (four_bit_adder)
// NUM_SLICES : number of slices chained to cover DATA_W
package sixteen_bit_adder_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned SLICE_W    = 4;
    localparam int unsigned NUM_SLICES = DATA_W / SLICE_W;

endpackage

// File: rtl/sixteen_bit_adder_if.sv
// Operand/result bundle for sixteen_bit_adder.
// a, b : unsigned addends        (master -> slave)
// ci   : carry-in                (master -> slave)
// s    : registered sum [15:0]   (slave -> master)
// co   : registered carry-out    (slave -> master)
interface sixteen_bit_adder_if;
    import sixteen_bit_adder_pkg::*;

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              ci;
    logic [DATA_W-1:0] s;
    logic              co;

    modport master (
        output a,
        output b,
        output ci,
        input  s,
        input  co
    );

    modport slave (
        input  a,
        input  b,
        input  ci,
        output s,
        output co
    );

endinterface

// File: rtl/sixteen_bit_adder_four_bit_adder.sv
// four_bit_adder: combinational 4-bit ripple-carry slice built from four
// 1-bit full-adder stages.
// a_i, b_i : 4-bit addends
// ci_i     : carry-in to bit 0
// s_o      : 4-bit sum
// co_o     : carry-out of bit 3
module four_bit_adder
    import sixteen_bit_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               ci_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               co_o
);

    // carry[i] is the carry into bit i; carry[SLICE_W] leaves the slice.
    logic [SLICE_W:0] carry;

    always_comb begin
        carry    = '0;
        s_o      = '0;
        carry[0] = ci_i;
        for (int i = 0; i < int'(SLICE_W); i++) begin
            s_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1] = (a_i[i] & b_i[i]) | (a_i[i] & carry[i]) | (b_i[i] & carry[i]);
        end
    end

    assign co_o = carry[SLICE_W];

endmodule

// File: rtl/sixteen_bit_adder.sv
// sixteen_bit_adder: registered 16-bit unsigned adder, {co,s} = a + b + ci,
// one cycle of latency, a new operand set accepted every cycle.
// clk : rising-edge clock
// rst : synchronous active-high reset, clears s and co
// bus : slave side of sixteen_bit_adder_if (a, b, ci in; s, co out)
module sixteen_bit_adder
    import sixteen_bit_adder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    sixteen_bit_adder_if.slave   bus
);

    // Ripple chain: slice k's carry-out feeds slice k+1's carry-in.
    logic [NUM_SLICES:0] slice_carry;
    logic [DATA_W-1:0]   sum_d;
    logic [DATA_W-1:0]   s_q;
    logic                co_q;

    assign slice_carry[0] = bus.ci;

    for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
        four_bit_adder u_four_bit_adder (
            .a_i  (bus.a[k*SLICE_W +: SLICE_W]),
            .b_i  (bus.b[k*SLICE_W +: SLICE_W]),
            .ci_i (slice_carry[k]),
            .s_o  (sum_d[k*SLICE_W +: SLICE_W]),
            .co_o (slice_carry[k+1])
        );
    end

    // Reset takes priority over any operands presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q  <= '0;
            co_q <= 1'b0;
        end else begin
            s_q  <= sum_d;
            co_q <= slice_carry[NUM_SLICES];
        end
    end

    assign bus.s  = s_q;
    assign bus.co = co_q;

endmodule

// File: tb/tb_sixteen_bit_adder.sv
// Directed testbench for sixteen_bit_adder: reset behaviour, increment sweep,
// wrap-around and slice-boundary carries, mid-stream reset, random vectors
// against a 17-bit reference sum.
module tb_sixteen_bit_adder;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] ref_sum;

    sixteen_bit_adder_if bus ();

    sixteen_bit_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands and reset, then step past the next rising edge.
    task automatic apply(input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic rv);
        bus.a  = av;
        bus.b  = bv;
        bus.ci = cv;
        rst    = rv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [16:0] exp_val);
        vectors++;
        assert ({bus.co, bus.s} === exp_val) else begin
            miscompares++;
            $error("FAIL %s: observed co=%b s=%h, expected co=%b s=%h",
                   tag, bus.co, bus.s, exp_val[16], exp_val[15:0]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.a       = '0;
        bus.b       = '0;
        bus.ci      = 1'b0;
        rst         = 1'b1;

        // Reset wins over operands that would otherwise produce a non-zero sum.
        apply(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        check("reset_with_max_operands", 17'h0_0000);
        apply(16'h1234, 16'h1111, 1'b0, 1'b1);
        check("reset_hold", 17'h0_0000);

        // Sweep: a = i, b = i/2, ci = 0; each edge's result is that cycle's a+b.
        for (int i = 0; i < 200; i++) begin
            apply(16'(i), 16'(i / 2), 1'b0, 1'b0);
            check("sweep", 17'(i + i / 2));
        end

        // Wrap-around and maximum case.
        apply(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("wrap_ffff_plus_1", 17'h1_0000);
        apply(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        check("max_ffff_ffff_ci", 17'h1_FFFF);
        apply(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        check("wrap_via_ci", 17'h1_0000);

        // Carries across each 4-bit slice boundary.
        apply(16'h000F, 16'h0001, 1'b0, 1'b0);
        check("carry_bit3_to_4", 17'h0_0010);
        apply(16'h00FF, 16'h0001, 1'b0, 1'b0);
        check("carry_bit7_to_8", 17'h0_0100);
        apply(16'h0FFF, 16'h0000, 1'b1, 1'b0);
        check("carry_bit11_to_12", 17'h0_1000);
        apply(16'h8000, 16'h8000, 1'b0, 1'b0);
        check("carry_bit15_out", 17'h1_0000);
        apply(16'h1234, 16'h4321, 1'b1, 1'b0);
        check("no_carry_mix", 17'h0_5556);
        apply(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check("no_signed_ovf_flag", 17'h0_8000);

        // Mid-stream reset discards the in-flight result; no replay afterwards.
        apply(16'hABCD, 16'h1111, 1'b0, 1'b0);
        check("pre_reset", 17'h0_BCDE);
        apply(16'h1234, 16'h1111, 1'b0, 1'b1);
        check("midstream_reset", 17'h0_0000);
        apply(16'h1234, 16'h1111, 1'b0, 1'b0);
        check("first_after_reset", 17'h0_2345);

        // Random operands against a zero-extended 17-bit reference.
        for (int i = 0; i < 10000; i++) begin
            ra      = 16'($urandom);
            rb      = 16'($urandom);
            rc      = 1'($urandom_range(1, 0));
            ref_sum = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            apply(ra, rb, rc, 1'b0);
            check("random", ref_sum);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
